apb_i2c_bridge_v2: RTL
======================

Name: apb_i2c_bridge_v2

Overview:
Parametrised next-generation APB slave between the system bus and the I2C core.
- Adds a full address decoder and a bounded-latency RX read path with wait states.
- Adds PSLVERR generation for bus-side faults and a maskable, sticky interrupt controller.
- Sits between the APB interconnect and the I2C core's TX/RX FIFOs, configuration and timeout inputs.

Parameters:
DATA_W, 32, APB data width and FIFO data width
ADDR_W, 8, decoded PADDR width; upper address bits are ignored
CFG_W, 14, width of CONFIG register
TO_W, 14, width of TIMEOUT register
RX_LAT, 1, cycles from rd_ena to read_data_on_rx valid (0..7)

Ports:
PCLK  in  1  clock
PRESET  in  1  reset, asynchronous, active-high
PSELx  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error, valid only with PREADY
wr_ena  out  1  one-cycle TX FIFO push
write_data_on_tx  out  DATA_W  TX push data
tx_full  in  1  TX FIFO full
tx_empty  in  1  TX FIFO empty
rd_ena  out  1  one-cycle RX FIFO pop
read_data_on_rx  in  DATA_W  RX data, valid RX_LAT cycles after rd_ena
rx_empty  in  1  RX FIFO empty
i2c_error  in  1  I2C core error level
cfg  out  CFG_W  CONFIG register
timeout  out  TO_W  TIMEOUT register
irq  out  1  registered interrupt

Behaviour:
Reset values: every output and register is 0. Edge-detector history resets to tx_empty_q=1, rx_empty_q=1, err_q=0.

Register map (PADDR[1:0] must be 0):
- 0x00 TXDATA W
- 0x04 RXDATA R
- 0x08 CONFIG RW
- 0x0C TIMEOUT RW
- 0x10 STATUS R = {i2c_error, rx_empty, tx_full, tx_empty} in bits [3:0]
- 0x14 IRQ_EN RW [2:0]
- 0x18 IRQ_STAT R/W1C [2:0]

FSM states: IDLE, ACCESS, RX_WAIT.
- IDLE -> ACCESS: PSELx & !PENABLE (setup phase).
- ACCESS, PENABLE=1: all transfers except a legal RXDATA read complete this cycle with PREADY=1 (combinational from state and decode) -> IDLE.
- Legal RXDATA read (rx_empty=0):
  - rd_ena pulses in the first ACCESS cycle.
  - RX_LAT=0: PREADY in that same cycle, with PRDATA=read_data_on_rx.
  - Otherwise -> RX_WAIT. A counter loads RX_LAT-1; at 0, PREADY=1, PRDATA=read_data_on_rx -> IDLE.
  - Total read latency is RX_LAT wait states.
- Legal TXDATA write (tx_full=0): wr_ena=1 and write_data_on_tx=PWDATA in the completing cycle.
- CONFIG/TIMEOUT/IRQ_EN writes update on the completing edge with PWDATA low bits.
- PSLVERR=1 with PREADY, no side effect, when any of:
  - the address is unmapped or misaligned;
  - the access is a write to a read-only register (RXDATA, STATUS);
  - the access is a read of TXDATA;
  - the access is a TXDATA write while tx_full=1;
  - the access is an RXDATA read while rx_empty=1. In this case PRDATA=0.
- PRDATA is 0 whenever PREADY=0 or PWRITE=1.
- PSELx drops during RX_WAIT: abort to IDLE, no PREADY. The pop has already happened and its data is discarded.
- IRQ_STAT sources:
  - bit0 sets on tx_empty rise;
  - bit1 sets on rx_empty fall (data arrived);
  - bit2 sets on i2c_error rise.
- IRQ_STAT bits are sticky. W1C clears them. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq is registered: irq <= |(IRQ_STAT & IRQ_EN). Latency is one cycle from the IRQ_STAT update.
- PRESET asserted mid-transfer: immediate return to IDLE, all outputs 0, no further wr_ena/rd_ena.

Decomposition:
- Package apb_i2c_pkg:
  - register offset constants;
  - state enum {IDLE, ACCESS, RX_WAIT};
  - IRQ bit indices (IRQ_TXE=0, IRQ_RXNE=1, IRQ_ERR=2);
  - STATUS bit indices.
- Sub-module apb_i2c_irq_ctrl: edge detection, sticky IRQ_STAT, W1C, mask, and registered irq.

Test Plan:
1. Reset, then write 0x0000_3FFF to 0x08 and 0x1234 to 0x0C -> cfg=14'h3FFF, timeout=14'h1234; PREADY in first ACCESS cycle; PSLVERR=0.
2. RX_LAT=2, rx_empty=0, read_data_on_rx=0xCAFE_F00D, read 0x04 -> rd_ena one cycle; PREADY two cycles later with PRDATA=0xCAFEF00D; single pop.
3. tx_full=1, write 0xAA to 0x00 -> PREADY=1, PSLVERR=1, wr_ena never asserts. Then tx_full=0 -> wr_ena=1, write_data_on_tx=0xAA.
4. Read 0x20, write 0x10, read 0x04 with rx_empty=1 -> PSLVERR=1 each; PRDATA=0; no rd_ena.
5. IRQ_EN=3'b100, pulse i2c_error -> IRQ_STAT=3'b100, irq=1 one cycle later. Write 0x4 to 0x18 during a second error rise -> bit2 stays 1. Then a clean W1C -> irq=0.
6. Assert PRESET in RX_WAIT -> PREADY, rd_ena, irq and cfg all 0 immediately; next transfer completes normally.

Source files
------------

// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB-to-I2C bridge.
//   - register byte offsets (PADDR[1:0] must be zero)
//   - bus FSM state encoding
//   - IRQ_STAT / IRQ_EN bit positions and STATUS bit positions
package apb_i2c_pkg;

    localparam logic [7:0] OFF_TXDATA   = 8'h00;
    localparam logic [7:0] OFF_RXDATA   = 8'h04;
    localparam logic [7:0] OFF_CONFIG   = 8'h08;
    localparam logic [7:0] OFF_TIMEOUT  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h14;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RX_WAIT = 2'd2
    } state_t;

    localparam int IRQ_TXE  = 0;
    localparam int IRQ_RXNE = 1;
    localparam int IRQ_ERR  = 2;
    localparam int IRQ_W    = 3;

    localparam int ST_TXE = 0;
    localparam int ST_TXF = 1;
    localparam int ST_RXE = 2;
    localparam int ST_ERR = 3;
    localparam int ST_W   = 4;

endpackage

// File: rtl/apb_i2c_bridge_v2_irq_ctrl.sv
// Interrupt controller for the APB-to-I2C bridge.
// Ports:
//   PCLK, PRESET             clock, asynchronous active-high reset
//   tx_empty, rx_empty       FIFO level flags from the I2C core
//   i2c_error                I2C core error level
//   irq_en   [IRQ_W-1:0]     interrupt mask (1 = enabled)
//   w1c      [IRQ_W-1:0]     one-cycle write-1-to-clear strobe
//   irq_stat [IRQ_W-1:0]     sticky event flags
//   irq                      registered, masked interrupt request
module apb_i2c_bridge_v2_irq_ctrl
    import apb_i2c_pkg::*;
(
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             tx_empty,
    input  logic             rx_empty,
    input  logic             i2c_error,
    input  logic [IRQ_W-1:0] irq_en,
    input  logic [IRQ_W-1:0] w1c,
    output logic [IRQ_W-1:0] irq_stat,
    output logic             irq
);

    // History starts as "FIFOs empty, no error" so reset itself raises no event.
    logic             tx_empty_q;
    logic             rx_empty_q;
    logic             err_q;
    logic [IRQ_W-1:0] set_vec;

    always_comb begin
        set_vec           = '0;
        set_vec[IRQ_TXE]  = tx_empty & ~tx_empty_q;
        set_vec[IRQ_RXNE] = ~rx_empty & rx_empty_q;
        set_vec[IRQ_ERR]  = i2c_error & ~err_q;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_empty_q <= 1'b1;
            rx_empty_q <= 1'b1;
            err_q      <= 1'b0;
            irq_stat   <= '0;
            irq        <= 1'b0;
        end else begin
            tx_empty_q <= tx_empty;
            rx_empty_q <= rx_empty;
            err_q      <= i2c_error;
            // A new event in the same cycle as its clear must not be lost.
            irq_stat   <= (irq_stat & ~w1c) | set_vec;
            irq        <= |(irq_stat & irq_en);
        end
    end

endmodule

// File: rtl/apb_i2c_bridge_v2.sv
// APB slave bridging the system bus to the I2C core FIFOs and registers.
// Ports:
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA   APB request
//   PRDATA/PREADY/PSLVERR        APB response (combinational)
//   wr_ena, write_data_on_tx     TX FIFO push
//   tx_full, tx_empty            TX FIFO flags
//   rd_ena, read_data_on_rx      RX FIFO pop; data valid RX_LAT cycles later
//   rx_empty                     RX FIFO flag
//   i2c_error                    I2C core error level
//   cfg, timeout                 CONFIG / TIMEOUT registers
//   irq                          registered interrupt
module apb_i2c_bridge_v2
    import apb_i2c_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CFG_W  = 14,
    parameter int TO_W   = 14,
    parameter int RX_LAT = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              wr_ena,
    output logic [DATA_W-1:0] write_data_on_tx,
    input  logic              tx_full,
    input  logic              tx_empty,
    output logic              rd_ena,
    input  logic [DATA_W-1:0] read_data_on_rx,
    input  logic              rx_empty,
    input  logic              i2c_error,
    output logic [CFG_W-1:0]  cfg,
    output logic [TO_W-1:0]   timeout,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(OFF_TXDATA);
    localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(OFF_RXDATA);
    localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(OFF_CONFIG);
    localparam logic [ADDR_W-1:0] A_TO   = ADDR_W'(OFF_TIMEOUT);
    localparam logic [ADDR_W-1:0] A_ST   = ADDR_W'(OFF_STATUS);
    localparam logic [ADDR_W-1:0] A_IEN  = ADDR_W'(OFF_IRQ_EN);
    localparam logic [ADDR_W-1:0] A_ISTA = ADDR_W'(OFF_IRQ_STAT);
    localparam bit                HAS_WAIT = (RX_LAT != 0);

    state_t           state, state_nxt;
    logic [2:0]       cnt;
    logic [IRQ_W-1:0] irq_en;
    logic [IRQ_W-1:0] irq_stat;
    logic [IRQ_W-1:0] w1c;
    logic [ST_W-1:0]  status;

    logic sel_tx, sel_rx, sel_cfg, sel_to, sel_st, sel_ien, sel_ista;
    logic mapped, bus_err, acc_phase, rx_pop, wr_cmplt;
    logic [DATA_W-1:0] rd_mux;

    // Offsets are all word aligned, so an exact match also checks alignment.
    assign sel_tx   = (PADDR == A_TX);
    assign sel_rx   = (PADDR == A_RX);
    assign sel_cfg  = (PADDR == A_CFG);
    assign sel_to   = (PADDR == A_TO);
    assign sel_st   = (PADDR == A_ST);
    assign sel_ien  = (PADDR == A_IEN);
    assign sel_ista = (PADDR == A_ISTA);
    assign mapped   = sel_tx | sel_rx | sel_cfg | sel_to | sel_st | sel_ien | sel_ista;

    assign bus_err = ~mapped
                   | ( PWRITE & (sel_rx | sel_st))
                   | (~PWRITE & sel_tx)
                   | ( PWRITE & sel_tx & tx_full)
                   | (~PWRITE & sel_rx & rx_empty);

    assign acc_phase = (state == ACCESS) & PSELx & PENABLE;
    assign rx_pop    = acc_phase & ~PWRITE & sel_rx & ~rx_empty;
    assign wr_cmplt  = acc_phase & PWRITE & ~bus_err;

    always_comb begin
        status         = '0;
        status[ST_TXE] = tx_empty;
        status[ST_TXF] = tx_full;
        status[ST_RXE] = rx_empty;
        status[ST_ERR] = i2c_error;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ACCESS && state_nxt == RX_WAIT) begin
                cnt <= 3'(RX_LAT - 1);
            end else if (state == RX_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (PSELx && !PENABLE) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!PSELx) begin
                    state_nxt = IDLE;
                end else if (PENABLE) begin
                    state_nxt = (rx_pop && HAS_WAIT) ? RX_WAIT : IDLE;
                end
            end
            RX_WAIT: begin
                // Dropping PSELx abandons the read; the popped word is lost.
                if (!PSELx || cnt == 3'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (PADDR)
            A_RX:    rd_mux = read_data_on_rx;
            A_CFG:   rd_mux = DATA_W'(cfg);
            A_TO:    rd_mux = DATA_W'(timeout);
            A_ST:    rd_mux = DATA_W'(status);
            A_IEN:   rd_mux = DATA_W'(irq_en);
            A_ISTA:  rd_mux = DATA_W'(irq_stat);
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        PREADY           = 1'b0;
        PSLVERR          = 1'b0;
        PRDATA           = '0;
        wr_ena           = 1'b0;
        write_data_on_tx = '0;
        rd_ena           = 1'b0;
        w1c              = '0;
        if (acc_phase) begin
            rd_ena  = rx_pop;
            PREADY  = ~(rx_pop & HAS_WAIT);
            PSLVERR = bus_err;
            if (PWRITE && sel_tx && !bus_err) begin
                wr_ena           = 1'b1;
                write_data_on_tx = PWDATA;
            end
            if (!PWRITE && !bus_err && PREADY) PRDATA = rd_mux;
            if (wr_cmplt && sel_ista) w1c = PWDATA[IRQ_W-1:0];
        end else if (state == RX_WAIT && PSELx && cnt == 3'd0) begin
            // rx_empty may already be set again after the pop, so bypass the
            // error decode and return the captured FIFO word directly.
            PREADY = 1'b1;
            PRDATA = read_data_on_rx;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cfg     <= '0;
            timeout <= '0;
            irq_en  <= '0;
        end else if (wr_cmplt) begin
            if (sel_cfg) cfg     <= PWDATA[CFG_W-1:0];
            if (sel_to)  timeout <= PWDATA[TO_W-1:0];
            if (sel_ien) irq_en  <= PWDATA[IRQ_W-1:0];
        end
    end

    apb_i2c_bridge_v2_irq_ctrl u_irq (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .tx_empty  (tx_empty),
        .rx_empty  (rx_empty),
        .i2c_error (i2c_error),
        .irq_en    (irq_en),
        .w1c       (w1c),
        .irq_stat  (irq_stat),
        .irq       (irq)
    );

endmodule
